score_display_ctrl: RTL and testbench

SCORE_DISPLAY_CTRL -- requirements
Module: score_display_ctrl

---
 rtl/score_display_ctrl.sv | 141 ++++++++++++++
 tb/tb_score_display_ctrl.sv | 118 +++++++++++
 2 files changed

// File: rtl/score_display_ctrl.sv
// score_display_ctrl
//   Converts a 14-bit binary score to 4-digit packed BCD for a multiplexed
//   seven-segment scanner. The conversion uses shift-and-add-3
//   (double dabble) and takes one bit per cycle. A free-running divider
//   produces the scan_tick enable that steps the external digit scanner.
//
//   Optional feature: define LEADING_ZERO_BLANK_EN to blank leading zero
//   digits. The ones digit is never blanked. Without the macro,
//   digit_blank is tied to 0.
//
// Ports
//   clk          system clock, all logic on posedge
//   rst          synchronous active-high reset
//   score[13:0]  binary score, sampled when a start is accepted
//   start        conversion request, accepted only in IDLE
//   busy         high while a conversion is in flight
//   done         one-cycle pulse when digit and digit_blank update
//   digit[15:0]  packed BCD {thousands, hundreds, tens, ones}
//   digit_blank  per-nibble blank mask, 1 = display off
//   scan_tick    one-cycle pulse every SCAN_DIV cycles
module score_display_ctrl #(
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [13:0] score,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [15:0] digit,
  output logic [3:0]  digit_blank,
  output logic        scan_tick
);

  localparam int unsigned CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);
  localparam logic [13:0] SCORE_MAX = 14'd9999;

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

  state_t      state, state_nx;
  logic [13:0] sreg;
  logic [15:0] scratch;
  logic [15:0] adj;
  logic [3:0]  iter;
  // Set on the edge that leaves COMMIT; the outputs load one edge later so
  // digit/done land on the 16th edge after start acceptance.
  logic        commit_pend;
  logic [CW-1:0] scan_cnt;

  // Add 3 to every BCD nibble >= 5 ahead of the shift.
  always_comb begin
    adj = scratch;
    for (int i = 0; i < 4; i++) begin
      if (scratch[4*i +: 4] >= 4'd5)
        adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
    end
  end

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = SHIFT;
      SHIFT:   if (iter == 4'd13) state_nx = COMMIT;
      COMMIT:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // ------------------------------------------------------------ datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      sreg        <= '0;
      scratch     <= '0;
      iter        <= '0;
      commit_pend <= 1'b0;
      digit       <= '0;
      done        <= 1'b0;
    end else begin
      done        <= 1'b0;
      commit_pend <= (state == COMMIT);
      case (state)
        IDLE: begin
          if (start) begin
            sreg    <= (score > SCORE_MAX) ? SCORE_MAX : score;
            scratch <= '0;
            iter    <= '0;
          end
        end
        SHIFT: begin
          {scratch, sreg} <= {adj[14:0], sreg, 1'b0};
          iter            <= iter + 4'd1;
        end
        default: ;
      endcase
      // scratch is untouched until the next accepted start, and a start on
      // this same edge only clears it after this read.
      if (commit_pend) begin
        digit <= scratch;
        done  <= 1'b1;
      end
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [3:0] blank_nx;

  // Blank a nibble only if it and every nibble above it are zero.
  always_comb begin
    blank_nx    = 4'b0000;
    blank_nx[3] = (scratch[15:12] == 4'd0);
    blank_nx[2] = blank_nx[3] && (scratch[11:8] == 4'd0);
    blank_nx[1] = blank_nx[2] && (scratch[7:4] == 4'd0);
  end

  always_ff @(posedge clk) begin
    if (rst)              digit_blank <= 4'b0000;
    else if (commit_pend) digit_blank <= blank_nx;
  end
`else
  assign digit_blank = 4'b0000;
`endif

  // --------------------------------------------------------- scan divider
  always_ff @(posedge clk) begin
    if (rst)                    scan_cnt <= '0;
    else if (scan_cnt == SCAN_LAST) scan_cnt <= '0;
    else                        scan_cnt <= scan_cnt + 1'b1;
  end

  assign scan_tick = (scan_cnt == SCAN_LAST);

endmodule

// File: tb/tb_score_display_ctrl.sv
// Directed bench for score_display_ctrl with SCAN_DIV=4.
module tb_score_display_ctrl;

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [3:0] BMASK = 4'b1111;
`else
  localparam logic [3:0] BMASK = 4'b0000;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [13:0] score;
  logic        start;
  logic        busy, done, scan_tick;
  logic [15:0] digit;
  logic [3:0]  digit_blank;

  int n_chk  = 0;
  int n_pass = 0;

  score_display_ctrl #(.SCAN_DIV(4)) dut (
    .clk(clk), .rst(rst), .score(score), .start(start), .busy(busy),
    .done(done), .digit(digit), .digit_blank(digit_blank),
    .scan_tick(scan_tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Start a conversion and follow it for 40 edges. inj > 0 pulses start
  // with score 777 right after edge inj to prove it is ignored.
  task automatic run_conv(input string tag, input logic [13:0] sc,
                          input logic [15:0] exp_d, input logic [3:0] exp_b,
                          input int inj);
    logic [15:0] prev;
    int busy_n, done_n, done_at;
    bit hold_ok;
    prev = digit; busy_n = 0; done_n = 0; done_at = -1; hold_ok = 1;
    score = sc; start = 1'b1;
    step();                       // accepting edge E0
    start = 1'b0;
    if (busy) busy_n++;
    for (int n = 1; n <= 40; n++) begin
      if (n == inj) begin score = 14'd777; start = 1'b1; end
      step();
      if (n == inj) start = 1'b0;
      if (busy) busy_n++;
      if (done) begin done_n++; if (done_at < 0) done_at = n; end
      if (n < 16 && digit !== prev) hold_ok = 0;
    end
    chk({tag, " latency"}, done_at, 16);
    chk({tag, " busy_cycles"}, busy_n, 15);
    chk({tag, " done_pulses"}, done_n, 1);
    chk({tag, " hold"}, hold_ok, 1);
    chk({tag, " digit"}, digit, exp_d);
    chk({tag, " blank"}, digit_blank, exp_b & BMASK);
  endtask

  initial begin
    logic [19:0] tick_exp;
    int done_n;
    rst = 1'b1; start = 1'b0; score = '0;
    step(); step();
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst digit", digit, 16'h0000);
    chk("rst blank", digit_blank, 4'b0000);
    chk("rst tick", scan_tick, 0);
    rst = 1'b0;

    // cycle k after reset release: tick at 3,7,11,15,19
    tick_exp = 20'b1000_1000_1000_1000_1000;
    for (int k = 0; k < 20; k++) begin
      chk($sformatf("tick c%0d", k), scan_tick, tick_exp[k]);
      step();
    end

    run_conv("s1234", 14'd1234, 16'h1234, 4'b0000, 0);
    run_conv("s16383", 14'd16383, 16'h9999, 4'b0000, 0);
    run_conv("s0", 14'd0, 16'h0000, 4'b1110, 0);
    run_conv("s7", 14'd7, 16'h0007, 4'b1110, 0);
    run_conv("s1005", 14'd1005, 16'h1005, 4'b0000, 0);
    run_conv("s10000", 14'd10000, 16'h9999, 4'b0000, 0);
    run_conv("s42inj", 14'd42, 16'h0042, 4'b1100, 5);

    // reset during SHIFT aborts: no done, digit cleared
    score = 14'd5678; start = 1'b1;
    step();
    start = 1'b0;
    for (int n = 1; n <= 8; n++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    done_n = 0;
    for (int n = 0; n < 20; n++) begin
      if (done) done_n++;
      step();
    end
    chk("abort done", done_n, 0);
    chk("abort digit", digit, 16'h0000);
    chk("abort busy", busy, 0);
    run_conv("s31", 14'd31, 16'h0031, 4'b1100, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
